md_unit_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts MD operations decoded in E, holds operands and sequences a fixed-latency busy window.
- Commits results to the HI/LO registers and serves mfhi/mflo reads.
- Its `busy` output and the E-stage op code drive the hazard unit's MD stall. The `req` input suppresses new work while an exception or interrupt is being taken.

---
 rtl/md_unit_sequencer.sv | 77 +++++++
 tb/tb_md_unit_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_sequencer.sv
// md_unit_sequencer: multi-cycle mult/div controller with HI/LO registers for the E stage.
// Results are computed at the start edge and held pending until the busy window ends.
module md_unit_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        div_zero;
    logic        is_mult, is_div, start, idle_ok;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0] res_hi, res_lo;

    assign busy    = cnt != 4'd0;
    assign idle_ok = !busy && !req;
    assign is_mult = md_op == 4'd1 || md_op == 4'd2;
    assign is_div  = md_op == 4'd3 || md_op == 4'd4;
    assign start   = idle_ok && (is_mult || is_div);
    assign md_out  = md_op == 4'd5 ? hi : md_op == 4'd6 ? lo : 32'd0;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    always_comb begin
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        abs_a  = rs_val[31] ? -rs_val : rs_val;
        abs_b  = rt_val[31] ? -rt_val : rt_val;
        div_b  = rt_val == 32'd0 ? 32'd1 : abs_b;
        q_mag  = abs_a / div_b;
        r_mag  = abs_a % div_b;
        q_s    = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
        r_s    = rs_val[31] ? -r_mag : r_mag;
        q_u    = rs_val / (rt_val == 32'd0 ? 32'd1 : rt_val);
        r_u    = rs_val % (rt_val == 32'd0 ? 32'd1 : rt_val);
        res_hi = md_op == 4'd1 ? prod_s[63:32] : md_op == 4'd2 ? prod_u[63:32] :
                 md_op == 4'd3 ? r_s : r_u;
        res_lo = md_op == 4'd1 ? prod_s[31:0] : md_op == 4'd2 ? prod_u[31:0] :
                 md_op == 4'd3 ? q_s : q_u;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            if (start) begin
                pend_hi  <= res_hi;
                pend_lo  <= res_lo;
                cnt      <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                div_zero <= is_div && rt_val == 32'd0;
            end else if (busy) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1 && !div_zero) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
            if (idle_ok && md_op == 4'd7) hi <= rs_val;
            if (idle_ok && md_op == 4'd8) lo <= rs_val;
        end
    end
endmodule

// File: tb/tb_md_unit_sequencer.sv
// tb_md_unit_sequencer: scoreboard bench; expected HI/LO pushed at issue, popped when busy falls.
module tb_md_unit_sequencer;
    logic        clk, reset, req, busy;
    logic [3:0]  md_op;
    logic [31:0] rs_val, rt_val, hi, lo, md_out;
    logic [63:0] sb_q[$];
    logic [31:0] exp_hi, exp_lo;
    int          n_tests, n_fail;

    md_unit_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
        .req(req), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Reference model on 64-bit longints; divide-by-zero keeps the current HI/LO.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [63:0] cur);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 4'd1) return 64'(sa * sb);
        if (op == 4'd2) return ua * ub;
        if (b == 32'd0) return cur;
        if (op == 4'd3) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Called at a negedge; kind 1 injects req+mult at busy cycle 2, kind 2 injects mthi there.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, input int n,
                          input int kind, input string nm);
        int cnt;
        logic [63:0] e;
        sb_q.push_back(model(op, a, b, {exp_hi, exp_lo}));
        md_op = op; rs_val = a; rt_val = b; req = 0;
        @(negedge clk);
        md_op = 0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 1) begin
                n_tests++;
                if (hi !== exp_hi || lo !== exp_lo) begin
                    n_fail++;
                    $display("FAIL %s_early_commit: hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, exp_hi, exp_lo);
                end
            end
            if (cnt == 2 && kind == 1) begin
                md_op = 1; rs_val = 32'h7; rt_val = 32'h9; req = 1;
            end else if (cnt == 2 && kind == 2) begin
                md_op = 7; rs_val = 32'hDEADBEEF;
            end else begin
                md_op = 0; req = 0;
            end
            @(negedge clk);
        end
        md_op = 0; req = 0;
        n_tests++;
        if (cnt != n) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", nm, cnt, n);
        end
        e = sb_q.pop_front();
        n_tests++;
        if ({hi, lo} !== e) begin
            n_fail++;
            $display("FAIL %s_result: hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, e[63:32], e[31:0]);
        end
        {exp_hi, exp_lo} = e;
    endtask

    task automatic check_hilo(input logic [31:0] h, l, input string nm);
        n_tests++;
        if (hi !== h || lo !== l) begin
            n_fail++;
            $display("FAIL %s: hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, h, l);
        end
    endtask

    task automatic test_reset;
        reset = 0; md_op = 0; rs_val = 0; rt_val = 0; req = 0;
        exp_hi = 0; exp_lo = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || md_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b md_out=%h want 0", busy, md_out);
        end
        check_hilo(32'd0, 32'd0, "reset_hilo");
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 0, "mult");
        check_hilo(32'hFFFFFFFF, 32'hFFFFFFFA, "mult_const");
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, 5, 0, "multu");
        check_hilo(32'h00000002, 32'hFFFFFFFA, "multu_const");
        run_op(4'd1, 32'h80000000, 32'h80000000, 5, 0, "mult_min");
    endtask

    task automatic test_div;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 0, "div");
        check_hilo(32'hFFFFFFFF, 32'hFFFFFFFD, "div_const");
        run_op(4'd4, 32'd7, 32'd2, 10, 0, "divu");
        check_hilo(32'd1, 32'd3, "divu_const");
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 0, "div_ovf");
        check_hilo(32'd0, 32'h80000000, "div_ovf_const");
        run_op(4'd3, 32'd100, 32'hFFFFFFF9, 10, 0, "div_neg_divisor");
    endtask

    task automatic test_mt_divzero;
        md_op = 7; rs_val = 32'h12345678;
        @(negedge clk);
        md_op = 8; rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        md_op = 0;
        exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
        check_hilo(32'h12345678, 32'h9ABCDEF0, "mthi_mtlo");
        run_op(4'd3, 32'd55, 32'd0, 10, 0, "div_zero");
        check_hilo(32'h12345678, 32'h9ABCDEF0, "div_zero_const");
        md_op = 5;
        #1;
        n_tests++;
        if (md_out !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mfhi: got %h want 12345678", md_out);
        end
        md_op = 6;
        #1;
        n_tests++;
        if (md_out !== 32'h9ABCDEF0) begin
            n_fail++;
            $display("FAIL mflo: got %h want 9abcdef0", md_out);
        end
        md_op = 0;
        @(negedge clk);
    endtask

    task automatic test_req;
        md_op = 1; rs_val = 32'd11; rt_val = 32'd13; req = 1;
        @(negedge clk);
        md_op = 0; req = 0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL req_block_busy: busy=%b want 0", busy);
        end
        check_hilo(exp_hi, exp_lo, "req_block_hilo");
        run_op(4'd1, 32'h00010001, 32'h00020003, 5, 1, "req_during_run");
    endtask

    task automatic test_reset_midop;
        md_op = 3; rs_val = 32'd1000; rt_val = 32'd7;
        @(negedge clk);
        md_op = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_busy: busy=%b want 0", busy);
        end
        check_hilo(32'd0, 32'd0, "midop_reset_hilo");
        @(negedge clk);
        reset = 1;
        exp_hi = 0; exp_lo = 0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_resume: busy=%b want 0", busy);
        end
        check_hilo(32'd0, 32'd0, "midop_no_commit");
    endtask

    task automatic test_back_to_back;
        run_op(4'd2, 32'hCAFEBABE, 32'h00001234, 5, 2, "mthi_while_busy");
        run_op(4'd1, 32'h00000010, 32'hFFFFFFF0, 5, 0, "b2b_first");
        run_op(4'd4, 32'hFFFFFFFF, 32'd10, 10, 0, "b2b_second");
        run_op(4'd1, 32'd3, 32'd4, 5, 0, "b2b_third");
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_mult();
        test_div();
        test_mt_divzero();
        test_req();
        test_reset_midop();
        test_back_to_back();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
